// File: rtl/ice_uart_pkg.sv
// Shared types and constants for the ice_uart 8N1 transceiver.
package ice_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam int DATA_BITS = 8;
    localparam int MIN_DIV   = 2;
    localparam int DIV_W     = 16;

    // Divisors below MIN_DIV cannot give a distinct mid-bit sample point.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        return (d < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : d;
    endfunction

endpackage

// File: rtl/ice_uart_if.sv
// Serial and byte-handshake signals of ice_uart; the host side is master.
interface ice_uart_if;
    import ice_uart_pkg::*;

    logic [DIV_W-1:0]     baud_div;
    logic                 rx_in;
    logic                 rx_latch;
    logic [DATA_BITS-1:0] rx_data;
    logic                 tx_out;
    logic                 tx_latch;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_empty;

    modport master (
        output baud_div, rx_in, tx_latch, tx_data,
        input  rx_latch, rx_data, tx_out, tx_empty
    );

    modport slave (
        input  baud_div, rx_in, tx_latch, tx_data,
        output rx_latch, rx_data, tx_out, tx_empty
    );

endinterface

// File: rtl/ice_uart_bitcnt.sv
// Bit-period down-counter: load starts a period of load_val cycles,
// expire is high in the last cycle of that period.
module ice_uart_bitcnt
    import ice_uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             expire
);

    logic [DIV_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val - DIV_W'(1);
        else if (cnt_q != '0)
            cnt_d = cnt_q - DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/ice_uart.sv
// Full-duplex 8N1 UART with runtime bit period; TX and RX halves are
// independent FSMs, each timed by its own ice_uart_bitcnt.
module ice_uart
    import ice_uart_pkg::*;
(
    input logic       clk,
    input logic       reset,
    ice_uart_if.slave bus
);

    uart_state_e          tx_state_q, tx_state_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic [2:0]           tx_idx_q, tx_idx_d;
    logic [DIV_W-1:0]     tx_div_q, tx_div_d, tx_load_val;
    logic                 tx_out_q, tx_out_d, tx_empty_q, tx_empty_d;
    logic                 tx_load, tx_expire;

    uart_state_e          rx_state_q, rx_state_d;
    logic [2:0]           rx_pipe_q, rx_pipe_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic [2:0]           rx_idx_q, rx_idx_d;
    logic [DIV_W-1:0]     rx_div_q, rx_div_d, rx_load_val;
    logic                 rx_ferr_q, rx_ferr_d, rx_latch_q, rx_latch_d;
    logic                 rx_load, rx_expire, rx_bit, rx_fall;

    ice_uart_bitcnt u_tx_cnt (.clk(clk), .reset(reset), .load(tx_load),
                              .load_val(tx_load_val), .expire(tx_expire));
    ice_uart_bitcnt u_rx_cnt (.clk(clk), .reset(reset), .load(rx_load),
                              .load_val(rx_load_val), .expire(rx_expire));

    // Transmitter: the counter is reloaded on every state change.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_sh_d     = tx_sh_q;
        tx_idx_d    = tx_idx_q;
        tx_div_d    = tx_div_q;
        tx_out_d    = tx_out_q;
        tx_empty_d  = tx_empty_q;
        tx_load     = 1'b0;
        tx_load_val = tx_div_q;
        case (tx_state_q)
            ST_IDLE: if (bus.tx_latch) begin
                tx_state_d  = ST_START;
                tx_sh_d     = bus.tx_data;
                tx_div_d    = eff_div(bus.baud_div);
                tx_out_d    = 1'b0;
                tx_empty_d  = 1'b0;
                tx_load     = 1'b1;
                tx_load_val = tx_div_d;
            end
            ST_START: if (tx_expire) begin
                tx_state_d = ST_DATA;
                tx_idx_d   = '0;
                tx_out_d   = tx_sh_q[0];
                tx_sh_d    = tx_sh_q >> 1;
                tx_load    = 1'b1;
            end
            ST_DATA: if (tx_expire) begin
                tx_load = 1'b1;
                if (tx_idx_q == 3'(DATA_BITS - 1)) begin
                    tx_state_d = ST_STOP;
                    tx_out_d   = 1'b1;
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                    tx_out_d = tx_sh_q[0];
                    tx_sh_d  = tx_sh_q >> 1;
                end
            end
            ST_STOP: if (tx_expire) begin
                tx_state_d = ST_IDLE;
                tx_empty_d = 1'b1;
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Receiver: rx_pipe_q[1:0] is the synchronizer, [2] the previous synced bit.
    always_comb begin
        rx_pipe_d   = {rx_pipe_q[1:0], bus.rx_in};
        rx_bit      = rx_pipe_q[1];
        rx_fall     = rx_pipe_q[2] & ~rx_pipe_q[1];
        rx_state_d  = rx_state_q;
        rx_sh_d     = rx_sh_q;
        rx_idx_d    = rx_idx_q;
        rx_div_d    = rx_div_q;
        rx_ferr_d   = rx_ferr_q;
        rx_data_d   = rx_data_q;
        rx_latch_d  = 1'b0;
        rx_load     = 1'b0;
        rx_load_val = rx_div_q;
        case (rx_state_q)
            ST_IDLE: if (rx_fall) begin
                rx_state_d  = ST_START;
                rx_div_d    = eff_div(bus.baud_div);
                rx_load     = 1'b1;
                rx_load_val = rx_div_d >> 1;
            end
            ST_START: if (rx_expire) begin
                if (rx_bit) begin
                    rx_state_d = ST_IDLE;
                end else begin
                    rx_state_d = ST_DATA;
                    rx_idx_d   = '0;
                    rx_load    = 1'b1;
                end
            end
            ST_DATA: if (rx_expire) begin
                rx_sh_d = {rx_bit, rx_sh_q[DATA_BITS-1:1]};
                rx_load = 1'b1;
                if (rx_idx_q == 3'(DATA_BITS - 1)) rx_state_d = ST_STOP;
                else                               rx_idx_d   = rx_idx_q + 3'd1;
            end
            ST_STOP: begin
                if (rx_ferr_q) begin
                    // Framing error: hold off until the line returns to idle.
                    if (rx_bit) begin
                        rx_state_d = ST_IDLE;
                        rx_ferr_d  = 1'b0;
                    end
                end else if (rx_expire) begin
                    if (rx_bit) begin
                        rx_state_d = ST_IDLE;
                        rx_data_d  = rx_sh_q;
                        rx_latch_d = 1'b1;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_out_q   <= 1'b1;
            tx_empty_q <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_pipe_q  <= 3'b111;
            rx_ferr_q  <= 1'b0;
            rx_latch_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_out_q   <= tx_out_d;
            tx_empty_q <= tx_empty_d;
            rx_state_q <= rx_state_d;
            rx_pipe_q  <= rx_pipe_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_latch_q <= rx_latch_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh_q  <= tx_sh_d;
        tx_idx_q <= tx_idx_d;
        tx_div_q <= tx_div_d;
        rx_sh_q  <= rx_sh_d;
        rx_idx_q <= rx_idx_d;
        rx_div_q <= rx_div_d;
    end

    assign bus.tx_out   = tx_out_q;
    assign bus.tx_empty = tx_empty_q;
    assign bus.rx_latch = rx_latch_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_ice_uart.sv
// Self-checking bench for ice_uart: frame-level reference model for TX
// waveform and RX byte delivery, directed scenarios plus random loopback.
`timescale 1ns/1ps
module tb_ice_uart;
    import ice_uart_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic loop = 1'b0;
    logic rx_drv = 1'b1;

    ice_uart_if bus();
    assign bus.rx_in = loop ? bus.tx_out : rx_drv;

    ice_uart dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         due;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model state: TX frame in flight and RX bytes owed.
    bit         m_busy = 1'b0;
    int         m_start = 0;
    logic [7:0] m_byte = 8'h00;
    int         m_div = 2;
    logic [7:0] m_last_rx = 8'h00;
    exp_t       rxq[$];
    exp_t       e_cur;
    logic [7:0] rx_log[$];

    function automatic int effd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_rx(input logic [7:0] b, input int due);
        exp_t t;
        t.b = b;
        t.due = due;
        rxq.push_back(t);
    endtask

    // Model: advances at each rising edge from the inputs the DUT sees.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_busy = 1'b0;
            m_last_rx = 8'h00;
            rxq.delete();
        end else if (m_busy) begin
            if (cyc - m_start == 10 * m_div) m_busy = 1'b0;
        end else if (bus.tx_latch) begin
            m_busy  = 1'b1;
            m_start = cyc;
            m_byte  = bus.tx_data;
            m_div   = effd(int'(bus.baud_div));
            if (loop) push_rx(bus.tx_data, cyc + 3 + m_div / 2 + 9 * m_div);
        end
    end

    // Compare: every falling edge, all outputs against the model.
    initial forever begin
        @(negedge clk);
        if (cyc != 0) begin
            chk("tx_empty", int'(bus.tx_empty), int'(!m_busy));
            chk("tx_out", int'(bus.tx_out),
                m_busy ? int'(frame_bit(m_byte, (cyc - m_start) / m_div)) : 1);
            if (bus.rx_latch) begin
                if (rxq.size() == 0) begin
                    chk("rx_latch_unexpected", int'(bus.rx_latch), 0);
                end else begin
                    e_cur = rxq.pop_front();
                    chk("rx_data", int'(bus.rx_data), int'(e_cur.b));
                    chk("rx_latency_window", int'((cyc >= e_cur.due - 1) && (cyc <= e_cur.due + 1)), 1);
                    m_last_rx = e_cur.b;
                    rx_log.push_back(bus.rx_data);
                end
            end else begin
                chk("rx_data_hold", int'(bus.rx_data), int'(m_last_rx));
                if (rxq.size() != 0 && cyc > rxq[0].due + 1) begin
                    chk("rx_latch_missing", int'(bus.rx_latch), 1);
                    void'(rxq.pop_front());
                end
            end
        end
    end

    task automatic send_tx(input logic [7:0] b);
        int w;
        w = 0;
        while (!bus.tx_empty && w < 3000) begin
            tick(1);
            w++;
        end
        chk("tx_ready_wait", int'(bus.tx_empty), 1);
        bus.tx_data  = b;
        bus.tx_latch = 1'b1;
        tick(1);
        bus.tx_latch = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    // Drives one frame on rx_in; abort_at >= 0 resets mid frame-bit abort_at.
    task automatic send_rx(input logic [7:0] b, input logic stop, input int abort_at);
        int d;
        d = effd(int'(bus.baud_div));
        if (stop) push_rx(b, cyc + 3 + d / 2 + 9 * d);
        for (int i = 0; i < 10; i++) begin
            rx_drv = (i == 9) ? stop : frame_bit(b, i);
            if (i == abort_at) begin
                tick(d / 2);
                reset = 1'b1;
                rx_drv = 1'b1;
                tick(1);
                reset = 1'b0;
                return;
            end
            tick(d);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [9:0] exp_wave;
        logic [7:0] lb_bytes [4];
        int k, rises, n0, w;
        logic prev_e;

        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_wave;
        logic [7:0] lb_bytes [4];
        int k, rises, n0, w;
        logic prev_e;

        bus.tx_latch = 1'b0;
        bus.tx_data  = 8'h00;
        bus.baud_div = 16'd10;
        tick(3);
        chk("reset_tx_out", int'(bus.tx_out), 1);
        chk("reset_tx_empty", int'(bus.tx_empty), 1);
        chk("reset_rx_latch", int'(bus.rx_latch), 0);
        chk("reset_rx_data", int'(bus.rx_data), 0);
        reset = 1'b0;
        tick(5);

        // TX waveform for 0xA5 at divisor 10, checked against literal bits.
        exp_wave = 10'b1101001010;
        send_tx(8'hA5);
        k = 0;
        while (!bus.tx_empty && k < 500) begin
            if (k % 10 == 5) chk("wave_a5_bit", int'(bus.tx_out), int'(exp_wave[k / 10]));
            k++;
            tick(1);
        end
        chk("wave_a5_empty_low_cycles", k, 100);
        tick(5);

        // Loopback, four bytes back to back.
        loop = 1'b1;
        lb_bytes[0] = 8'h62; lb_bytes[1] = 8'h0c; lb_bytes[2] = 8'h08; lb_bytes[3] = 8'hf0;
        n0 = rx_log.size();
        for (int i = 0; i < 4; i++) send_tx(lb_bytes[i]);
        w = 0;
        while (rx_log.size() < n0 + 4 && w < 2000) begin tick(1); w++; end
        tick(20);
        chk("loopback_count", rx_log.size() - n0, 4);
        for (int i = 0; i < 4 && n0 + i < rx_log.size(); i++)
            chk("loopback_byte", int'(rx_log[n0 + i]), int'(lb_bytes[i]));

        // Latch while busy must be ignored.
        send_tx(8'hDE);
        tick(30);
        bus.tx_data = 8'h00;
        bus.tx_latch = 1'b1;
        tick(1);
        bus.tx_latch = 1'b0;
        rises = 0;
        prev_e = bus.tx_empty;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (bus.tx_empty && !prev_e) rises++;
            prev_e = bus.tx_empty;
        end
        chk("busy_ignore_empty_rises", rises, 1);
        chk("busy_ignore_last_rx", int'(rx_log[rx_log.size() - 1]), 8'hDE);
        loop = 1'b0;
        tick(10);

        // Framing error then a good frame.
        n0 = rx_log.size();
        send_rx(8'h55, 1'b0, -1);
        tick(20);
        send_rx(8'h72, 1'b1, -1);
        tick(30);
        chk("ferr_then_good_count", rx_log.size() - n0, 1);
        if (rx_log.size() > n0) chk("ferr_then_good_byte", int'(rx_log[n0]), 8'h72);

        // Short glitch must not start a frame; receiver still works after.
        n0 = rx_log.size();
        rx_drv = 1'b0;
        tick(3);
        rx_drv = 1'b1;
        tick(40);
        chk("glitch_no_latch", rx_log.size() - n0, 0);
        send_rx(8'h3C, 1'b1, -1);
        tick(30);
        chk("after_glitch_byte", int'(rx_log[rx_log.size() - 1]), 8'h3C);

        // Reset during TX data bit 4.
        send_tx(8'hC3);
        tick(5 * 10 + 5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("tx_reset_tx_out", int'(bus.tx_out), 1);
        chk("tx_reset_tx_empty", int'(bus.tx_empty), 1);
        tick(5);
        send_tx(8'h5A);
        tick(110);

        // Reset during RX data bit 4.
        n0 = rx_log.size();
        send_rx(8'h9A, 1'b1, 5);
        chk("rx_reset_rx_latch", int'(bus.rx_latch), 0);
        chk("rx_reset_rx_data", int'(bus.rx_data), 0);
        tick(120);
        chk("rx_reset_no_byte", rx_log.size() - n0, 0);
        send_rx(8'hB7, 1'b1, -1);
        tick(30);
        chk("rx_reset_next_byte", int'(rx_log[rx_log.size() - 1]), 8'hB7);

        // Random loopback with varying divisor, including 0 and 1.
        loop = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.baud_div = 16'($urandom_range(0, 12));
            send_tx(8'($urandom));
            tick(4);
            if ($urandom_range(0, 1) == 1) begin
                bus.tx_data = 8'($urandom);
                bus.tx_latch = 1'b1;
                tick(1);
                bus.tx_latch = 1'b0;
            end
            tick($urandom_range(0, 5));
        end

        w = 0;
        while ((rxq.size() != 0 || !bus.tx_empty) && w < 3000) begin tick(1); w++; end
        tick(20);
        chk("final_rx_drained", rxq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
